// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson sequencing controller.
package johnson_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // Bits needed to index every state of a 2*width Johnson sequence.
   function automatic int unsigned ph_width(input int unsigned width);
      return $clog2(2 * width);
   endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson register with forward/reverse step, IDLE load and phase decode.
// JOHNSON_CHECK_EN enables the load legality check and the err pulse.
module johnson_core
   import johnson_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned PH_W  = ph_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic [PH_W-1:0]  phase,
   output logic             err
);

   localparam int unsigned SEQ_LEN = 2 * WIDTH;

   logic load_ok;

`ifdef JOHNSON_CHECK_EN
   // Johnson states have at most one boundary between the 1-run and the 0-run.
   assign load_ok = $countones(load_val[WIDTH-2:0] ^ load_val[WIDTH-1:1]) <= 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err <= 1'b0;
      else       err <= load && !load_ok;
   end
`else
   assign load_ok = 1'b1;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         if (load_ok) cnt <= load_val;
      end else if (step) begin
         if (dir == DIR_REV) cnt <= {~cnt[0], cnt[WIDTH-1:1]};
         else                cnt <= {cnt[WIDTH-2:0], ~cnt[WIDTH-1]};
      end
   end

   // Upper half of the ring counts down from 2*WIDTH as the 1-run drains.
   assign phase = cnt[WIDTH-1] ? PH_W'(SEQ_LEN - 32'($countones(cnt)))
                               : PH_W'($countones(cnt));

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run/pause/abort sequencer driving an embedded Johnson counter.
// Optional macro JOHNSON_CHECK_EN: reject illegal loads and pulse err.
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   parameter  int unsigned CNT_W = 8,
   localparam int unsigned PH_W  = ph_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] steps,
   input  logic             dir,
   input  logic             pause,
   input  logic             abort,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic [PH_W-1:0]  phase,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state, next_state;
   logic [CNT_W-1:0] remaining, remaining_nxt;
   logic             run_dir, run_dir_nxt;
   logic             step_c;
   logic             load_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         run_dir   <= DIR_FWD;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= next_state;
         remaining <= remaining_nxt;
         run_dir   <= run_dir_nxt;
         busy      <= (next_state == RUN) || (next_state == HOLD);
         done      <= (next_state == DONE);
      end
   end

   // Next state; abort beats pause beats advance while a run is active.
   always_comb begin
      next_state    = state;
      remaining_nxt = remaining;
      run_dir_nxt   = run_dir;
      step_c        = 1'b0;
      load_c        = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               load_c = 1'b1;
            end else if (start) begin
               run_dir_nxt = dir;
               if (steps == '0) begin
                  next_state = DONE;
               end else begin
                  remaining_nxt = steps;
                  next_state    = RUN;
               end
            end
         end
         RUN, HOLD: begin
            if (abort) begin
               next_state = IDLE;
            end else if (pause) begin
               next_state = HOLD;
            end else begin
               step_c        = 1'b1;
               remaining_nxt = remaining - CNT_W'(1);
               next_state    = (remaining == CNT_W'(1)) ? DONE : RUN;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   johnson_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .step     (step_c),
      .dir      (run_dir),
      .load     (load_c),
      .load_val (load_val),
      .cnt      (cnt),
      .phase    (phase),
      .err      (err)
   );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios plus random traffic
// against a phase-index model of the Johnson ring.
module tb_johnson_seq_ctrl;

   localparam int W  = 4;
   localparam int CW = 8;
   localparam int N  = 2 * W;

   logic          clk = 1'b0;
   logic          reset, start, dir, pause, abort, load;
   logic [CW-1:0] steps;
   logic [W-1:0]  load_val;
   logic [W-1:0]  cnt;
   logic [2:0]    phase;
   logic          busy, done, err;

   int tests = 0;
   int fails = 0;

   // Reference: position on the ring, steps left, run/done/err flags.
   int mp, mrem;
   bit mbusy, mdone, merr, mdir;

   johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .steps(steps), .dir(dir),
      .pause(pause), .abort(abort), .load(load), .load_val(load_val),
      .cnt(cnt), .phase(phase), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Ring position p: p ones growing from the LSB, then zeros growing from the LSB.
   function automatic logic [W-1:0] pat(input int p);
      logic [W-1:0] v;
      if (p < W) v = W'((1 << p) - 1);
      else       v = W'(((1 << (N - p)) - 1) << (p - W));
      return v;
   endfunction

   function automatic int idx_of(input logic [W-1:0] v);
      for (int p = 0; p < N; p++)
         if (pat(p) == v) return p;
      return -1;
   endfunction

   task automatic model_reset();
      mp = 0; mrem = 0; mbusy = 0; mdone = 0; merr = 0; mdir = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_cnt"},   32'(cnt),   32'(pat(mp)));
      check({tag, "_phase"}, 32'(phase), 32'(mp));
      check({tag, "_busy"},  32'(busy),  32'(mbusy));
      check({tag, "_done"},  32'(done),  32'(mdone));
      check({tag, "_err"},   32'(err),   32'(merr));
   endtask

   // One clock with the given inputs; model advances and every output is compared.
   task automatic cyc(input string tag, input bit st, input int stp, input bit d,
                      input bit pz, input bit ab, input bit ld, input logic [W-1:0] lv);
      bit nd, ne;
      int i;
      start = st; steps = CW'(stp); dir = d; pause = pz; abort = ab;
      load = ld; load_val = lv;
      nd = 0; ne = 0;
      if (mdone) begin
      end else if (mbusy) begin
         if (ab) mbusy = 0;
         else if (!pz) begin
            mp = (mp + (mdir ? N - 1 : 1)) % N;
            mrem--;
            if (mrem == 0) begin mbusy = 0; nd = 1; end
         end
      end else if (ld) begin
         i = idx_of(lv);
         if (i >= 0) mp = i;
         else        ne = 1;
      end else if (st) begin
         mdir = d;
         if (stp == 0) nd = 1;
         else begin mrem = stp; mbusy = 1; end
      end
      mdone = nd; merr = ne;
      @(posedge clk); #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 0, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic load0();
      cyc("ld0", 0, 0, 0, 0, 0, 1, '0);
   endtask

   initial begin
      int dcnt;
      reset = 1; start = 0; steps = '0; dir = 0; pause = 0; abort = 0;
      load = 0; load_val = '0;
      model_reset();
      #2;
      check_all("rst");
      @(posedge clk); #1;
      reset = 0;

      // Forward 8: full lap, phase 1..7 then 0, single done on the 8th advance.
      cyc("f8_start", 1, 8, 0, 0, 0, 0, '0);
      dcnt = 0;
      for (int i = 1; i <= 8; i++) begin
         idle("f8");
         check("f8_ph", 32'(phase), 32'(i % 8));
         check("f8_done", 32'(done), 32'(i == 8));
         dcnt += int'(done);
      end
      check("f8_done_count", 32'(dcnt), 32'd1);
      idle("f8_end");

      // Reverse 3 from zero.
      cyc("r3_start", 1, 3, 1, 0, 0, 0, '0);
      check("r3_busy0", 32'(busy), 32'd1);
      idle("r3"); check("r3_c1", 32'(cnt), 32'b1000);
      idle("r3"); check("r3_c2", 32'(cnt), 32'b1100);
      idle("r3"); check("r3_c3", 32'(cnt), 32'b1110);
      check("r3_ph", 32'(phase), 32'd5);
      check("r3_busy_end", 32'(busy), 32'd0);
      idle("r3_end");

      // Pause two cycles after the 2nd advance.
      load0();
      cyc("p6_start", 1, 6, 0, 0, 0, 0, '0);
      idle("p6"); idle("p6");
      cyc("p6_hold", 0, 0, 0, 1, 0, 0, '0); check("p6_h1", 32'(cnt), 32'b0011);
      cyc("p6_hold", 0, 0, 0, 1, 0, 0, '0); check("p6_h2", 32'(cnt), 32'b0011);
      for (int i = 0; i < 4; i++) idle("p6");
      check("p6_final", 32'(cnt), 32'b1100);
      check("p6_done", 32'(done), 32'd1);
      idle("p6_end");

      // Abort after 4 advances, then an immediate restart.
      load0();
      cyc("ab_start", 1, 10, 0, 0, 0, 0, '0);
      for (int i = 0; i < 4; i++) idle("ab");
      cyc("ab_abort", 0, 0, 0, 0, 1, 0, '0);
      check("ab_cnt", 32'(cnt), 32'b1111);
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_done", 32'(done), 32'd0);
      cyc("ab_restart", 1, 1, 0, 0, 0, 0, '0);
      check("ab_restart_busy", 32'(busy), 32'd1);
      idle("ab_fin");
      check("ab_fin_done", 32'(done), 32'd1);
      idle("ab_end");

`ifdef JOHNSON_CHECK_EN
      load0();
      cyc("chk_bad", 0, 0, 0, 0, 0, 1, 4'b0101);
      check("chk_bad_err", 32'(err), 32'd1);
      check("chk_bad_cnt", 32'(cnt), 32'd0);
      idle("chk_clr");
      check("chk_err_clr", 32'(err), 32'd0);
      cyc("chk_good", 0, 0, 0, 0, 0, 1, 4'b1100);
      check("chk_good_ph", 32'(phase), 32'd6);
`endif

      // Asynchronous reset in the middle of a long run.
      load0();
      cyc("rr_start", 1, 20, 0, 0, 0, 0, '0);
      idle("rr"); idle("rr"); idle("rr");
      #2 reset = 1;
      #1;
      model_reset();
      check_all("rr_async");
      @(posedge clk); #1;
      reset = 0;
      cyc("z_start", 1, 0, 0, 0, 0, 0, '0);
      check("z_done", 32'(done), 32'd1);
      check("z_busy", 32'(busy), 32'd0);
      check("z_cnt", 32'(cnt), 32'd0);
      idle("z_end");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         bit st, d, pz, ab, ld;
         int stp;
         logic [W-1:0] lv;
         st  = ($urandom_range(0, 3) == 0);
         stp = int'($urandom_range(0, 20));
         d   = 1'($urandom_range(0, 1));
         pz  = ($urandom_range(0, 4) == 0);
         ab  = ($urandom_range(0, 24) == 0);
         ld  = ($urandom_range(0, 9) == 0);
         lv  = pat(int'($urandom_range(0, N - 1)));
`ifdef JOHNSON_CHECK_EN
         if ($urandom_range(0, 1) == 1) lv = W'($urandom);
`endif
         cyc("rnd", st, stp, d, pz, ab, ld, lv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Sequencing controller for a Johnson (twisted-ring) counter. It accepts a run command carrying a step count and direction, then advances an embedded Johnson register one state per clock. It supports pause and abort, and reports completion with a one-cycle pulse. It sits between the software/FSM command layer and any logic that consumes the Johnson phase (for example, multi-phase enables). It also outputs the decoded phase index.

## Interface
- `WIDTH`, default 4: Johnson register width; the sequence has 2*WIDTH states.
- `CNT_W`, default 8: width of the step-count field.
- `PH_W`, derived as $clog2(2*WIDTH): phase index width. Not overridable.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: run request, sampled only in IDLE.
- `steps` in CNT_W: number of advances, latched on an accepted start.
- `dir` in 1: direction, latched on an accepted start. 0 = forward, 1 = reverse.
- `pause` in 1: level; suppresses advance while high.
- `abort` in 1: level; terminates the run without done.
- `load` in 1: loads `load_val` into the counter, honoured only in IDLE.
- `load_val` in WIDTH: value to load.
- `cnt` out WIDTH: Johnson register.
- `phase` out PH_W: decoded index of `cnt`.
- `busy` out 1: high in RUN or HOLD.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle illegal-load pulse. Tied 0 unless JOHNSON_CHECK_EN is defined.

## Operation
- States are IDLE, RUN, HOLD, DONE.
- Reset values: state = IDLE, `cnt` = 0, `phase` = 0, `busy` = 0, `done` = 0, `err` = 0, remaining = 0. Reset asserted mid-run returns everything to these values immediately.
- Forward step: cnt <= {cnt[WIDTH-2:0], ~cnt[WIDTH-1]}. For WIDTH=4 the sequence is 0000→0001→0011→0111→1111→1110→1100→1000→0000.
- Reverse step: cnt <= {~cnt[0], cnt[WIDTH-1:1]}, which is the exact inverse of forward.
- Phase decode: if cnt[WIDTH-1]=0 then phase = popcount(cnt), else phase = 2*WIDTH − popcount(cnt). Phase is combinational from `cnt`.
- IDLE:
  - `load`=1: `cnt` ← `load_val`. Load wins over a simultaneous `start`, which is dropped.
  - Otherwise `start`=1 latches `steps` and `dir`.
  - If `steps`=0 the next state is DONE; else remaining ← steps and the next state is RUN.
- RUN/HOLD, priority abort > pause > advance:
  - `abort`=1: go to IDLE. `cnt` holds, `done` is not pulsed.
  - `pause`=1: no advance, go to HOLD (stay in HOLD while paused).
  - Otherwise: advance `cnt` and decrement remaining. If remaining was 1, go to DONE; else go to RUN.
- DONE: `done`=1 for this cycle only, then go to IDLE unconditionally. `start`/`load` are ignored here.
- `start`/`load` while busy are ignored and not queued.
- Wrap-around is free-running: the count modulo 2*WIDTH is allowed, and `steps` greater than 2*WIDTH simply laps.

## Timing
- Accepted start at edge k: `busy`=1 after edge k. Advances occur at edges k+1 … k+N, where N = `steps` with no pause.
- DONE is entered at edge k+N, so `done`=1 in cycle k+N to k+N+1 and `busy` falls at edge k+N.
- `steps`=0: DONE follows edge k directly, `busy` never rises, and `cnt` is unchanged.
- Each paused cycle extends the run by exactly one cycle.
- Loaded value is visible after the load edge. `err` is registered and pulses in the same cycle.

## Configuration
- Macro: `JOHNSON_CHECK_EN`.
- Defined:
  - A `load_val` is legal iff the count of adjacent-bit transitions (bit i vs i+1, i = 0..WIDTH-2) is ≤ 1.
  - An illegal load is rejected: `cnt` is unchanged and `err` pulses for 1 cycle.
- Undefined:
  - Any `load_val` is loaded verbatim and `err` is constant 0.
  - Stepping from an illegal value follows the same shift equations; the result is undefined sequence membership, which is acceptable.

## Structure
- Package `johnson_pkg`:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3);
  - direction constants DIR_FWD=0 and DIR_REV=1;
  - phase-width helper.
- Sub-module `johnson_core`:
  - holds the `cnt` register with `step`, `dir`, `load`, `load_val` inputs;
  - contains the phase decode and, under the macro, the legality check.
- `johnson_seq_ctrl` holds the FSM, the remaining-step counter and the latched `dir`.

## Test plan
- WIDTH=4, `cnt`=0000, start with steps=8, dir=0: `cnt` walks 0001…1000 then back to 0000, phase walks 1..7 then 0. `done` pulses exactly once, 8 cycles after the start edge.
- `cnt`=0000, start with steps=3, dir=1: `cnt` goes 1000, 1100, 1110, with final phase=5. `busy` is high for 3 cycles.
- steps=6, dir=0, `pause` held for 2 cycles after the 2nd advance: `cnt` holds at 0011 for 2 cycles, ends at 1100, and `done` is 2 cycles late.
- steps=10, `abort` after 4 advances: `cnt`=1111 is retained, no `done`, and the FSM returns to IDLE. A new start is accepted on the next cycle.
- With `JOHNSON_CHECK_EN`:
  - load 0101: `err`=1 for 1 cycle and `cnt` is unchanged.
  - load 1100: accepted, phase=6.
- `reset` asserted mid-run with steps=20: all outputs are 0 asynchronously. start with steps=0 then gives `done` one cycle later, `busy` stays 0, and `cnt` stays 0000.
